// File: rtl/thresh_pkg.sv
// Shared definitions for the threshold pipeline: raster geometry defaults, pixel
// width and the writer/scan state encoding.
package thresh_pkg;

  localparam int DEF_WIDTH_BITS  = 8;
  localparam int DEF_HEIGHT_BITS = 8;
  localparam int DEF_ADDR_WIDTH  = DEF_WIDTH_BITS + DEF_HEIGHT_BITS;
  localparam int PIX_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/output_ram64k.sv
// 64K x 8 single-port output RAM: registered write, registered read data.
module output_ram64k (
  input  logic        clock,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  input  logic        wren,
  output logic [7:0]  q
);

  logic [7:0] mem [0:65535];

  always_ff @(posedge clock) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end

endmodule

// File: rtl/raster_counter.sv
// Raster-order column/row counter with synchronous clear, step enable and a
// combinational flag marking the last pixel of the frame.
module raster_counter #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   step_i,
  output logic [WIDTH_BITS-1:0]  col_o,
  output logic [HEIGHT_BITS-1:0] row_o,
  output logic                   last_o
);

  logic [WIDTH_BITS-1:0]  col_q;
  logic [HEIGHT_BITS-1:0] row_q;
  logic                   col_max;

  assign col_max = (col_q == {WIDTH_BITS{1'b1}});

  always_ff @(posedge clock) begin
    if (reset || clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (step_i) begin
      if (col_max) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_max && (row_q == {HEIGHT_BITS{1'b1}});

endmodule

// File: rtl/output_ram_writer.sv
// Raster-stream sink writing one frame per iStart into output_ram64k, 1-cycle write latency.
// Optional OUTPUT_RAM_WRITER_CHECKSUM_EN adds a 16-bit running pixel sum on oChecksum.
module output_ram_writer
  import thresh_pkg::*;
#(
  parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  input  logic                   iValid,
  input  logic [PIX_W-1:0]       iData,
  output logic                   oReady,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [WIDTH_BITS-1:0]  oCol,
`ifdef OUTPUT_RAM_WRITER_CHECKSUM_EN
  output logic [HEIGHT_BITS-1:0] oRow,
  output logic [15:0]            oChecksum
`else
  output logic [HEIGHT_BITS-1:0] oRow
`endif
);

  state_e                 state_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic [ADDR_WIDTH-1:0]  ram_addr_q;
  logic [PIX_W-1:0]       ram_data_q;
  logic                   ram_wren_q;
  logic [PIX_W-1:0]       unused_ram_q;

  logic                   accept;
  logic                   cnt_clr;
  logic                   cnt_last;
  logic [WIDTH_BITS-1:0]  col;
  logic [HEIGHT_BITS-1:0] row;

  // ready_q is only ever high in WRITE, so it alone qualifies an accept
  assign accept  = iValid && ready_q;
  assign cnt_clr = (state_q == ST_IDLE) && iStart;

  raster_counter #(
    .WIDTH_BITS  (WIDTH_BITS),
    .HEIGHT_BITS (HEIGHT_BITS)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .step_i (accept),
    .col_o  (col),
    .row_o  (row),
    .last_o (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_wren_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      ram_wren_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            state_q <= ST_WRITE;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            ram_addr_q <= (ADDR_WIDTH'(row) << WIDTH_BITS) + ADDR_WIDTH'(col);
            ram_data_q <= iData;
            ram_wren_q <= 1'b1;
            if (cnt_last) begin
              state_q <= ST_FLUSH;
              ready_q <= 1'b0;
            end
          end
        end
        // final registered write lands on the RAM during this state
        ST_FLUSH: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef OUTPUT_RAM_WRITER_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clock) begin
    if (reset || cnt_clr) csum_q <= '0;
    else if (accept)      csum_q <= csum_q + 16'(iData);
  end

  assign oChecksum = csum_q;
`endif

  output_ram64k u_ram (
    .clock   (clock),
    .address (ram_addr_q),
    .data    (ram_data_q),
    .wren    (ram_wren_q),
    .q       (unused_ram_q)
  );

  assign oReady = ready_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;
  assign oCol   = col;
  assign oRow   = row;

endmodule

// File: tb/tb_output_ram_writer.sv
// Self-checking bench for output_ram_writer: reset/handshake vector table plus
// full-frame and reset-abort sequences checked against a frame-level model.
module tb_output_ram_writer;

  localparam int N = 65536;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iStart = 1'b0;
  logic       iValid = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady, oBusy, oDone;
  logic [7:0] oCol, oRow;
`ifdef OUTPUT_RAM_WRITER_CHECKSUM_EN
  logic [15:0] oChecksum;
`endif

  output_ram_writer dut (
    .clock     (clock),
    .reset     (reset),
    .iStart    (iStart),
    .iValid    (iValid),
    .iData     (iData),
    .oReady    (oReady),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oCol      (oCol),
`ifdef OUTPUT_RAM_WRITER_CHECKSUM_EN
    .oRow      (oRow),
    .oChecksum (oChecksum)
`else
    .oRow      (oRow)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dat;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] exp_mem [0:N-1];
  int         wr_err = 0;
  logic [15:0] csum_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Raster order means the k-th accepted pixel belongs at address k.
  function automatic logic [7:0] pix(input int mode, input int k);
    if (mode == 0) return 8'(k) ^ 8'(k >> 8);
    return 8'(k);
  endfunction

  // Every RAM write must match the oldest pixel the model says was accepted.
  always @(negedge clock) begin
    if (dut.ram_wren_q === 1'b1) begin
      if (exp_q.size() == 0) begin
        wr_err++;
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (dut.ram_addr_q !== e.addr || dut.ram_data_q !== e.dat) wr_err++;
      end
    end
  end

  task automatic run_frame(input int mode, input int rst_at, input int limit);
    int   k = 0;
    int   last_acc = -1;
    int   done_cnt = 0;
    int   done_it = -1;
    int   st_err = 0;
    int   werr0;
    bit   pulsed = 0;
    logic vld;
    werr0  = wr_err;
    csum_m = 16'h0;
    iStart = 1'b1;
    @(posedge clock); #1;
    iStart = 1'b0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      vld    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      iValid = vld;
      iData  = pix(mode, k);
      iStart = (k == 100) && !pulsed;
      if (iStart) pulsed = 1;
      if (oReady !== (k < N)) st_err++;
      if (k == rst_at) begin
        reset  = 1'b1;
        iValid = 1'b1;
        iStart = 1'b0;
        @(posedge clock); #1;
        reset  = 1'b0;
        iValid = 1'b0;
        chk("rst_busy", oBusy, 0);
        chk("rst_ready", oReady, 0);
        chk("rst_wren", dut.ram_wren_q, 0);
        chk("rst_ram_last_written", dut.u_ram.mem[rst_at-1], exp_mem[rst_at-1]);
        chk("rst_ram_untouched", dut.u_ram.mem[rst_at], exp_mem[rst_at]);
`ifdef OUTPUT_RAM_WRITER_CHECKSUM_EN
        chk("rst_checksum", oChecksum, 0);
`endif
        repeat (4) begin
          @(posedge clock); #1;
          if (oDone !== 1'b0) done_cnt++;
          if (dut.ram_wren_q !== 1'b0) st_err++;
        end
        chk("rst_no_done", done_cnt, 0);
        chk("rst_handshake", st_err, 0);
        chk("rst_writes", wr_err - werr0 + exp_q.size(), 0);
        return;
      end
      @(posedge clock); #1;
      if (vld && k < N) begin
        exp_mem[k] = iData;
        exp_q.push_back({16'(k), iData});
        csum_m = csum_m + 16'(iData);
        k++;
        last_acc = cyc;
        if (k == 255) begin
          chk("wrap_pre_col", oCol, 255);
          chk("wrap_pre_row", oRow, 0);
        end
        if (k == 256) begin
          chk("wrap_col", oCol, 0);
          chk("wrap_row", oRow, 1);
          chk("wrap_addr", dut.ram_addr_q, 16'h00FF);
        end
      end
      if (oDone === 1'b1) begin
        done_cnt++;
        done_it = cyc;
        if (oBusy !== 1'b0) st_err++;
      end
      if (k == N && cyc > last_acc + 6) break;
    end
    iValid = 1'b0;
    chk("accepts", k, N);
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_it - last_acc + 1, 2);
    chk("handshake", st_err, 0);
    chk("write_stream", wr_err - werr0, 0);
    chk("writes_pending", exp_q.size(), 0);
    chk("busy_after", oBusy, 0);
`ifdef OUTPUT_RAM_WRITER_CHECKSUM_EN
    chk("checksum", oChecksum, csum_m);
`endif
  endtask

  typedef struct {
    logic       rst, st, vld;
    logic [7:0] dat;
    logic       rdy, busy, done, wren;
    logic [7:0] col, row;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int bad;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

    for (int i = 0; i < 7; i++) begin
      reset  = tbl[i].rst;
      iStart = tbl[i].st;
      iValid = tbl[i].vld;
      iData  = tbl[i].dat;
      @(posedge clock); #1;
      chk($sformatf("vec%0d", i),
          {8'h0, oReady, oBusy, oDone, dut.ram_wren_q, 4'h0, oCol, oRow},
          {8'h0, tbl[i].rdy, tbl[i].busy, tbl[i].done, tbl[i].wren, 4'h0, tbl[i].col, tbl[i].row});
    end
    reset  = 1'b0;
    iStart = 1'b0;
    iValid = 1'b0;
    @(posedge clock); #1;

    // Full frame, iValid held high, data = col ^ row, stray iStart at pixel 100.
    run_frame(0, -1, N + 200);
    chk("ram_1234", dut.u_ram.mem[16'h1234], 8'h26);
    chk("ram_FFFF", dut.u_ram.mem[16'hFFFF], 8'h00);
    chk("ram_00FF", dut.u_ram.mem[16'h00FF], 8'hFF);
    bad = 0;
    for (int a = 0; a < N; a++) if (dut.u_ram.mem[a] !== exp_mem[a]) bad++;
    chk("ram_image", bad, 0);

    // iValid in IDLE must not produce ready or any write.
    bad = 0;
    iValid = 1'b1;
    iData  = 8'hC3;
    repeat (8) begin
      @(posedge clock); #1;
      if (oReady !== 1'b0 || oBusy !== 1'b0 || dut.ram_wren_q !== 1'b0) bad++;
    end
    iValid = 1'b0;
    chk("idle_ignores_valid", bad, 0);

    // Random 50% iValid, data = col, reset asserted when pixel 1000 is offered.
    run_frame(1, 1000, 5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
